// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int MAX_DBIT = 9;
  function automatic logic parity_bit(input logic [MAX_DBIT-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: frame request and serial-line signals of the UART transmitter
interface uart_tx_cfg_if #(parameter int DBIT = 8);
  logic Tx_start;
  logic [DBIT-1:0] din;
  logic Tx;
  logic tx_busy;
  logic o_Tx_Done;
  modport master (output Tx_start, din, input Tx, tx_busy, o_Tx_Done);
  modport slave (input Tx_start, din, output Tx, tx_busy, o_Tx_Done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: CLKS_PER_BIT cycle counter with clear and one-cycle bit-end strobe
module uart_baud_tick #(parameter int CLKS_PER_BIT = 39) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter; define UART_TX_PARITY_EN to insert a parity bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 39,
  parameter int DBIT = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic reset,
  uart_tx_cfg_if.slave bus
);
  localparam int IW = $clog2(DBIT);
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("CLKS_PER_BIT out of range");
  end
  if (DBIT < 5 || DBIT > MAX_DBIT) begin : g_bad_dbit
    $error("DBIT out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_odd
    $error("PARITY_ODD must be 0 or 1");
  end
  uart_state_e state;
  logic [DBIT-1:0] data;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic stop_n;
  logic tx_r, busy_r, done_r;
  logic tick;
  assign idx_n = idx + IW'(1);
  assign bus.Tx = tx_r;
  assign bus.tx_busy = busy_r;
  assign bus.o_Tx_Done = done_r;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst(reset),
    .clr(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx_r <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      idx <= '0;
      stop_n <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.Tx_start) begin
          data <= bus.din;
          state <= START;
          tx_r <= 1'b0;
          busy_r <= 1'b1;
        end
        START: if (tick) begin
          state <= DATA;
          tx_r <= data[0];
          idx <= '0;
        end
        DATA: if (tick) begin
          if (idx == IW'(DBIT - 1)) begin
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx_r <= parity_bit(MAX_DBIT'(data), 1'(PARITY_ODD));
`else
            state <= STOP;
            tx_r <= 1'b1;
`endif
          end else begin
            idx <= idx_n;
            tx_r <= data[idx_n];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx_r <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          if (stop_n == 1'(STOP_BITS - 1)) begin
            stop_n <= 1'b0;
            state <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else
            stop_n <= stop_n + 1'b1;
        end
        default: begin
          state <= IDLE;
          tx_r <= 1'b1;
          busy_r <= 1'b0;
          idx <= '0;
          stop_n <= 1'b0;
        end
      endcase
    end
endmodule
